// File: rtl/multi_digit_code_conv.sv
// Digit-serial converter between 8,4,-2,-1 code and BCD, one digit per cycle, MSD first.
// Optional binary accumulator output bin_out is enabled by defining CODE_CONV_BINARY_EN.
module multi_digit_code_conv #(
  parameter int DIGITS = 4,
  parameter int MODE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_code,
  output logic [DIGITS-1:0]     out_err_mask,
  output logic                  out_err
`ifdef CODE_CONV_BINARY_EN
  ,
  output logic [4*DIGITS-1:0]   bin_out
`endif
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [W-1:0]       r_in_code;
  logic [W-1:0]       r_out_code;
  logic [DIGITS-1:0]  r_err_mask;
  logic               r_err;
  logic [2:0]         r_idx;

  logic [3:0]         w_dig;
  logic [3:0]         w_res;
  logic [3:0]         w_val;
  logic               w_ill;
  logic               w_accept;

  // Returns {illegal, result}; the same table is read in either direction depending on MODE.
  function automatic logic [4:0] conv_digit(input logic [3:0] d);
    logic [4:0] r;
    r = 5'h10;
    if (MODE == 0) begin
      case (d)
        4'b0000: r = 5'h00;
        4'b0111: r = 5'h01;
        4'b0110: r = 5'h02;
        4'b0101: r = 5'h03;
        4'b0100: r = 5'h04;
        4'b1011: r = 5'h05;
        4'b1010: r = 5'h06;
        4'b1001: r = 5'h07;
        4'b1000: r = 5'h08;
        4'b1111: r = 5'h09;
        default: r = 5'h10;
      endcase
    end else begin
      case (d)
        4'd0:    r = 5'b0_0000;
        4'd1:    r = 5'b0_0111;
        4'd2:    r = 5'b0_0110;
        4'd3:    r = 5'b0_0101;
        4'd4:    r = 5'b0_0100;
        4'd5:    r = 5'b0_1011;
        4'd6:    r = 5'b0_1010;
        4'd7:    r = 5'b0_1001;
        4'd8:    r = 5'b0_1000;
        4'd9:    r = 5'b0_1111;
        default: r = 5'h10;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    w_dig = 4'b0000;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == 3'(i)) w_dig = r_in_code[i*4 +: 4];
    end
    {w_ill, w_res} = conv_digit(w_dig);
    // Decimal weight of the digit: decoded value in MODE 0, the BCD input itself in MODE 1.
    if (w_ill)          w_val = 4'b0000;
    else if (MODE == 0) w_val = w_res;
    else                w_val = w_dig;
  end

  assign w_accept = r_in_ready & in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_code   <= '0;
      r_out_code  <= '0;
      r_err_mask  <= '0;
      r_err       <= 1'b0;
      r_idx       <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_in_code  <= in_code;
            r_idx      <= 3'(DIGITS - 1);
            r_out_code <= '0;
            r_err_mask <= '0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= CONV;
          end
        end
        CONV: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == 3'(i)) begin
              r_out_code[i*4 +: 4] <= w_res;
              r_err_mask[i]        <= w_ill;
            end
          end
          r_err <= r_err | w_ill;
          if (r_idx == 3'd0) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx - 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CODE_CONV_BINARY_EN
  logic [W-1:0] r_bin;
  logic [W-1:0] w_bin_next;

  // x*10 as (x<<3)+(x<<1); wraps at W bits.
  assign w_bin_next = (r_bin << 3) + (r_bin << 1) + W'(w_val);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin <= '0;
    end else if (r_state == IDLE && w_accept) begin
      r_bin <= '0;
    end else if (r_state == CONV) begin
      r_bin <= w_bin_next;
    end
  end

  assign bin_out = r_bin;
`endif

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_code     = r_out_code;
  assign out_err_mask = r_err_mask;
  assign out_err      = r_err;

endmodule

// File: doc/multi_digit_code_conv.md
MULTI_DIGIT_CODE_CONV -- requirements
Module: multi_digit_code_conv

Interface
REQ-001 SHALL provide parameter DIGITS, default 4, giving the number of 4-bit decimal digits per word (legal range 1..8).
REQ-002 SHALL provide parameter MODE, default 0, where 0 converts 8,4,-2,-1 code to BCD and 1 converts BCD to 8,4,-2,-1 code.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port in_valid, input, 1 bit: the input word is present.
REQ-006 SHALL provide port in_ready, output, 1 bit: the block can accept a word.
REQ-007 SHALL provide port in_code, input, 4*DIGITS bits: packed digits, with digit DIGITS-1 (most significant) in the top nibble.
REQ-008 SHALL provide port out_valid, output, 1 bit: the result is present.
REQ-009 SHALL provide port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL provide port out_code, output, 4*DIGITS bits: the converted digits, with the same packing as in_code.
REQ-011 SHALL provide port out_err_mask, output, DIGITS bits: bit i is set when input digit i was an illegal code.
REQ-012 SHALL provide port out_err, output, 1 bit: the OR of out_err_mask.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, CONV, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; in_valid while in_ready=1 captures in_code, loads digit index DIGITS-1, clears the working result and moves to CONV.
REQ-015 SHALL, in CONV, convert exactly one digit per cycle, most significant first, writing the result nibble and error bit at the current index.
REQ-016 SHALL use this code table: 0=0000, 1=0111, 2=0110, 3=0101, 4=0100, 5=1011, 6=1010, 7=1001, 8=1000, 9=1111.
REQ-017 SHALL, for MODE=0, treat 0001, 0010, 0011, 1100, 1101 and 1110 as illegal; for MODE=1, treat 1010 through 1111 as illegal.
REQ-018 SHALL, for an illegal digit, write result nibble 0000 and set the corresponding out_err_mask bit.
REQ-019 SHALL, after converting index 0, move to DONE with out_valid=1; out_valid rises at the DIGITS-th rising edge after the accepting edge.
REQ-020 SHALL hold out_code, out_err_mask, out_err (and bin_out) stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, in DONE with out_ready=1, deassert out_valid at the next edge and return to IDLE; minimum word period is DIGITS+2 cycles.
REQ-022 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.
REQ-023 SHALL, with DIGITS=1, visit CONV for exactly one cycle.

Reset
REQ-024 SHALL, while reset=1 at a rising edge, enter IDLE and clear out_valid, out_code, out_err_mask, out_err, the digit index and bin_out to 0.
REQ-025 SHALL let reset take priority over every handshake, including reset asserted mid-CONV or in DONE; the in-flight word is discarded and no out_valid pulse is produced.
REQ-026 SHALL drive in_ready=1 on the first edge after reset deasserts.

Configuration
REQ-027 SHALL, when macro CODE_CONV_BINARY_EN is defined, add output port bin_out, 4*DIGITS bits, holding the unsigned binary value of the decimal result.
REQ-028 SHALL compute bin_out in CONV as bin_out = bin_out*10 + digit value, with an illegal digit contributing 0, and truncate to 4*DIGITS bits.
REQ-029 SHALL, without CODE_CONV_BINARY_EN, omit port bin_out and its multiply-accumulate logic, with all other behaviour identical.

Verification
REQ-030 SHALL cover: DIGITS=4, MODE=0, in_code=16'h7FFB -> out_code=16'h1995, out_err_mask=4'b0000, bin_out=16'h07CB, with out_valid rising exactly 4 cycles after acceptance.
REQ-031 SHALL cover: DIGITS=4, MODE=0, in_code=16'h7123 -> out_code=16'h1000, out_err_mask=4'b0111, out_err=1, bin_out=16'h03E8.
REQ-032 SHALL cover: DIGITS=4, MODE=1, in_code=16'h0429 -> out_code=16'h046F, out_err=0; and in_code=16'h0A00 -> out_err_mask=4'b0100.
REQ-033 SHALL cover: out_ready held low for 5 cycles in DONE -> outputs stable, in_ready=0 and new in_valid ignored; out_ready=1 -> IDLE on the next edge.
REQ-034 SHALL cover: reset pulsed during the second CONV cycle -> all outputs 0, no out_valid, and in_ready=1 on the first edge after reset deasserts.
REQ-035 SHALL cover: DIGITS=1 exhaustive sweep of 16 codes in both modes -> table and error flags match REQ-016 through REQ-018, with latency of 1 cycle.
